// File: rtl/bf_io_controller.sv
// UART <-> brainfuck core glue: load/run mode tracking, RX/TX byte FIFOs,
// loader strobe with optional echo, and the held-start handshake toward the UART.

module bf_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// state  | meaning
// S_IDLE | no byte outstanding; pops TX head when UART is idle
// S_REQ  | tx_start held with stable tx_data until UART drops tx_ready
// S_BUSY | UART shifting the byte; wait for tx_ready to return
module bf_io_controller #(
    parameter int DATA_W      = 8,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int CODE_ADDR_W = 9,
    parameter int PROBE_W     = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_reset,
    input  logic                   i_loading,
    input  logic                   i_echo_en,
    input  logic                   i_rx_done,
    input  logic [DATA_W-1:0]      i_rx_data,
    input  logic                   i_tx_ready,
    output logic                   o_tx_start,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic                   o_load_start,
    output logic                   o_loader_we,
    output logic [DATA_W-1:0]      o_loader_data,
    output logic                   o_core_in_valid,
    output logic [DATA_W-1:0]      o_core_in_data,
    input  logic                   i_core_in_ack,
    input  logic                   i_core_out_valid,
    input  logic [DATA_W-1:0]      i_core_out_data,
    output logic                   o_core_out_ready,
    input  logic [CODE_ADDR_W-1:0] i_code_addr,
    output logic [PROBE_W-1:0]     o_addr_probe,
    output logic                   o_rx_overflow,
    output logic                   o_tx_overflow
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} tx_state_t;

    tx_state_t         r_tx_state;
    tx_state_t         w_tx_next;
    logic              w_tx_pop;
    logic              r_loading_q;
    logic              r_load_start;
    logic              r_loader_we;
    logic [DATA_W-1:0] r_loader_data;
    logic [DATA_W-1:0] r_tx_data;
    logic [PROBE_W-1:0] r_addr_probe;
    logic              r_rx_ovf;
    logic              r_tx_ovf;
    logic              w_edge;
    logic              w_run;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_echo_push;
    logic              w_core_push;
    logic              w_tx_push;
    logic [DATA_W-1:0] w_tx_wdata;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_unused_addr;

    assign w_unused_addr = ^i_code_addr;

    // Either edge of loading flushes both FIFOs; mode follows the registered copy.
    assign w_edge = i_loading ^ r_loading_q;
    assign w_run  = ~r_loading_q;

    assign o_core_in_valid = w_run & ~w_rx_empty;
    assign o_core_in_data  = o_core_in_valid ? w_rx_head : '0;
    assign w_rx_push       = w_run & i_rx_done;
    assign w_rx_pop        = o_core_in_valid & i_core_in_ack;

    assign o_core_out_ready = w_run & (~w_tx_full | w_tx_pop);
    assign w_echo_push      = r_loading_q & i_rx_done & i_echo_en;
    assign w_core_push      = i_core_out_valid & o_core_out_ready;
    assign w_tx_push        = w_echo_push | w_core_push;
    assign w_tx_wdata       = w_echo_push ? i_rx_data : i_core_out_data;

    bf_io_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_sys_clk),
        .i_reset (i_reset),
        .i_flush (w_edge),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (i_rx_data),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    bf_io_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk   (i_sys_clk),
        .i_reset (i_reset),
        .i_flush (w_edge),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (w_tx_wdata),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) r_tx_state <= S_IDLE;
        else         r_tx_state <= w_tx_next;
    end

    // No new byte is started on a flush cycle, since its head is being discarded.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            S_IDLE: if (!w_tx_empty && i_tx_ready && !w_edge) begin
                w_tx_pop  = 1'b1;
                w_tx_next = S_REQ;
            end
            S_REQ:  if (!i_tx_ready) w_tx_next = S_BUSY;
            S_BUSY: if (i_tx_ready)  w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_loading_q   <= 1'b0;
            r_load_start  <= 1'b0;
            r_loader_we   <= 1'b0;
            r_loader_data <= '0;
            r_tx_data     <= '0;
            r_addr_probe  <= '0;
            r_rx_ovf      <= 1'b0;
            r_tx_ovf      <= 1'b0;
        end else begin
            r_loading_q  <= i_loading;
            r_load_start <= i_loading & ~r_loading_q;
            r_loader_we  <= r_loading_q & i_rx_done;
            r_addr_probe <= i_code_addr[PROBE_W-1:0];
            if (r_loading_q && i_rx_done) r_loader_data <= i_rx_data;
            if (w_tx_pop) r_tx_data <= w_tx_head;
            if (w_edge) begin
                r_rx_ovf <= 1'b0;
                r_tx_ovf <= 1'b0;
            end else begin
                if (w_rx_push && w_rx_full && !w_rx_pop)   r_rx_ovf <= 1'b1;
                if (w_echo_push && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
            end
        end
    end

    assign o_tx_start    = (r_tx_state == S_REQ);
    assign o_tx_data     = r_tx_data;
    assign o_load_start  = r_load_start;
    assign o_loader_we   = r_loader_we;
    assign o_loader_data = r_loader_data;
    assign o_addr_probe  = r_addr_probe;
    assign o_rx_overflow = r_rx_ovf;
    assign o_tx_overflow = r_tx_ovf;
endmodule
